// File: rtl/uart_cmd_assembler.sv
// Pairs received UART bytes (high byte first) into 16-bit commands for the command FSM.
// Includes an inter-byte timeout and a sticky flag for commands overwritten before being taken.
module uart_cmd_assembler #(
  parameter int TIMEOUT_CYC = 104160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        timeout_err,
  output logic        overrun,
  input  logic        clr_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_LOW = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [7:0]    highByte_q, highByte_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmdRdy_q, cmdRdy_d;
  logic          pending_q, pending_d;
  logic          timeoutErr_q, timeoutErr_d;
  logic          overrun_q, overrun_d;

  assign clr_rx_rdy  = rx_rdy;
  assign cmd         = cmd_q;
  assign cmd_rdy     = cmdRdy_q;
  assign timeout_err = timeoutErr_q;
  assign overrun     = overrun_q;

  // pending_q remembers an untaken command even after a new high byte drops cmd_rdy,
  // so the following completion can still be flagged as an overrun.
  always_comb begin
    state_d      = state_q;
    highByte_d   = highByte_q;
    count_d      = count_q;
    cmd_d        = cmd_q;
    cmdRdy_d     = cmdRdy_q;
    pending_d    = pending_q;
    timeoutErr_d = 1'b0;
    overrun_d    = overrun_q;

    if (clr_cmd_rdy) begin
      cmdRdy_d  = 1'b0;
      pending_d = 1'b0;
    end
    if (clr_err) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          highByte_d = rx_data;
          count_d    = '0;
          cmdRdy_d   = 1'b0;
          state_d    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // A byte arriving on the terminal count still completes the command.
        if (rx_rdy) begin
          cmd_d     = {highByte_q, rx_data};
          cmdRdy_d  = 1'b1;
          pending_d = 1'b1;
          count_d   = '0;
          state_d   = IDLE;
          if (pending_q && !clr_cmd_rdy) begin
            overrun_d = 1'b1;
          end
        end else if (count_q == TERM) begin
          highByte_d   = 8'h00;
          count_d      = '0;
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      highByte_q   <= 8'h00;
      count_q      <= '0;
      cmd_q        <= 16'h0000;
      cmdRdy_q     <= 1'b0;
      pending_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      highByte_q   <= highByte_d;
      count_q      <= count_d;
      cmd_q        <= cmd_d;
      cmdRdy_q     <= cmdRdy_d;
      pending_q    <= pending_d;
      timeoutErr_q <= timeoutErr_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a short timeout and a receiver model
// that drops rx_rdy on the edge after clr_rx_rdy is seen.
module tb_uart_cmd_assembler;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        timeout_err;
  logic        overrun;
  logic        clr_err;

  int total = 0;
  int bad   = 0;

  uart_cmd_assembler #(.TIMEOUT_CYC(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .timeout_err(timeout_err),
    .overrun(overrun),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for exactly one edge; the receiver clears on the consume strobe.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    checkOutput("clrRxHigh", {15'b0, clr_rx_rdy}, 16'd1);
    @(posedge clk);
    #1;
    if (clr_rx_rdy) rx_rdy = 1'b0;
    #1;
    checkOutput("clrRxLow", {15'b0, clr_rx_rdy}, 16'd0);
  endtask

  task automatic pulseClrCmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    clr_cmd_rdy = 1'b0; clr_err = 1'b0;
    #12;
    checkOutput("rstCmd", cmd, 16'h0000);
    checkOutput("rstCmdRdy", {15'b0, cmd_rdy}, 16'd0);
    checkOutput("rstTmo", {15'b0, timeout_err}, 16'd0);
    checkOutput("rstOvr", {15'b0, overrun}, 16'd0);
    checkOutput("rstClrRx", {15'b0, clr_rx_rdy}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Basic pair
    applyStimulus(8'hA5);
    checkOutput("midCmdRdy", {15'b0, cmd_rdy}, 16'd0);
    applyStimulus(8'h3C);
    checkOutput("cmdA53C", cmd, 16'hA53C);
    checkOutput("rdyA53C", {15'b0, cmd_rdy}, 16'd1);
    checkOutput("tmoA53C", {15'b0, timeout_err}, 16'd0);
    checkOutput("ovrA53C", {15'b0, overrun}, 16'd0);

    // New high byte drops cmd_rdy, clear while low has no effect, then complete
    applyStimulus(8'h12);
    checkOutput("dropOnHigh", {15'b0, cmd_rdy}, 16'd0);
    checkOutput("cmdHeld", cmd, 16'hA53C);
    pulseClrCmd();
    checkOutput("clrWhileLow", {15'b0, cmd_rdy}, 16'd0);
    applyStimulus(8'h34);
    checkOutput("cmd1234", cmd, 16'h1234);
    checkOutput("rdy1234", {15'b0, cmd_rdy}, 16'd1);
    checkOutput("ovr1234", {15'b0, overrun}, 16'd0);
    pulseClrCmd();
    checkOutput("clrRdy", {15'b0, cmd_rdy}, 16'd0);
    checkOutput("cmdAfterClr", cmd, 16'h1234);

    // Timeout: high byte captured at E0, pulse visible after E64
    applyStimulus(8'h55);
    for (int i = 1; i < 64; i++) begin
      tick();
      checkOutput($sformatf("noTmo%0d", i), {15'b0, timeout_err}, 16'd0);
    end
    tick();
    checkOutput("tmoPulse", {15'b0, timeout_err}, 16'd1);
    checkOutput("tmoCmdKept", cmd, 16'h1234);
    tick();
    checkOutput("tmoOneCyc", {15'b0, timeout_err}, 16'd0);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkOutput("cmd0102", cmd, 16'h0102);
    checkOutput("rdy0102", {15'b0, cmd_rdy}, 16'd1);
    checkOutput("ovr0102", {15'b0, overrun}, 16'd0);
    pulseClrCmd();

    // Low byte on the terminal-count cycle wins over the timeout
    applyStimulus(8'h66);
    for (int i = 1; i < 64; i++) tick();
    applyStimulus(8'h77);
    checkOutput("cmdTerm", cmd, 16'h6677);
    checkOutput("rdyTerm", {15'b0, cmd_rdy}, 16'd1);
    checkOutput("tmoTerm", {15'b0, timeout_err}, 16'd0);
    tick();
    checkOutput("tmoTermLate", {15'b0, timeout_err}, 16'd0);
    pulseClrCmd();

    // Overrun
    applyStimulus(8'hBE);
    applyStimulus(8'hEF);
    checkOutput("cmdBEEF", cmd, 16'hBEEF);
    checkOutput("ovrBEEF", {15'b0, overrun}, 16'd0);
    applyStimulus(8'hCA);
    applyStimulus(8'hFE);
    checkOutput("cmdCAFE", cmd, 16'hCAFE);
    checkOutput("rdyCAFE", {15'b0, cmd_rdy}, 16'd1);
    checkOutput("ovrSet", {15'b0, overrun}, 16'd1);
    tick();
    checkOutput("ovrSticky", {15'b0, overrun}, 16'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("ovrCleared", {15'b0, overrun}, 16'd0);

    // Async reset mid-command
    applyStimulus(8'h77);
    rst_n = 1'b0;
    #1;
    checkOutput("arstCmd", cmd, 16'h0000);
    checkOutput("arstRdy", {15'b0, cmd_rdy}, 16'd0);
    checkOutput("arstOvr", {15'b0, overrun}, 16'd0);
    checkOutput("arstTmo", {15'b0, timeout_err}, 16'd0);
    #10;
    rst_n = 1'b1;
    tick();
    applyStimulus(8'h88);
    applyStimulus(8'h99);
    checkOutput("cmd8899", cmd, 16'h8899);
    checkOutput("rdy8899", {15'b0, cmd_rdy}, 16'd1);
    checkOutput("ovr8899", {15'b0, overrun}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
